hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Generalised pipeline hazard and stall controller for the RISCV64 five-stage core. It replaces the single-cycle branch stall with a stateful unit.
- Holds IF/ID across a variable-latency branch until EX resolves it, and flushes on a taken branch.
- Also detects load-use hazards and honours multi-cycle EX occupancy, such as MUL/DIV.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX enables and flushes.

Parameters:
- REG_AW, 5, register address width.
- BR_TIMEOUT, 15, maximum BR_WAIT cycles before a forced release.
- CNT_W, $clog2(BR_TIMEOUT+1), watchdog counter width (derived).
- PERF_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  2  ID-stage branch type; 2'b00 = not a branch/jump.
- br_resolved  in  1  EX pulse: the branch held in EX has resolved.
- br_taken  in  1  qualifies br_resolved: redirect required.
- id_rs1, id_rs2  in  REG_AW  ID-stage source registers.
- id_use_rs1, id_use_rs2  in  1  source-valid flags.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_busy  in  1  EX is occupied by a multi-cycle op.
- pc_stall  out  1  hold PC.
- if_id_cstall  out  1  control stall of IF/ID.
- if_id_dstall  out  1  data/structural stall of IF/ID.
- if_id_flush  out  1  squash IF/ID.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- id_ex_stall  out  1  hold ID/EX.
- br_timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- The clock is clk; reset is rst_n, asynchronous and active-low.
- While rst_n=0:
  - state=IDLE, counter=0, br_timeout_err=0.
  - All stall, flush and bubble outputs are forced 0.
- Outputs are combinational from the registered state plus current inputs, so they take effect in the same cycle. State and counter update on posedge clk.
- Load-use hazard (lu):
  - lu = id_ex_memread && id_ex_rd!=0 && ((id_use_rs1 && id_rs1==id_ex_rd) || (id_use_rs2 && id_rs2==id_ex_rd)).
- Priority: ex_busy > lu > branch.
- ex_busy=1, any state:
  - pc_stall=1, if_id_dstall=1, id_ex_stall=1, id_ex_bubble=0.
  - br_resolved is ignored.
  - The counter is frozen and the state does not change.
- lu=1 and ex_busy=0:
  - pc_stall=1, if_id_dstall=1, id_ex_bubble=1 for exactly that cycle. No state is stored.
  - A branch in ID that also has lu is not accepted until lu clears.
- States: IDLE, BR_WAIT.
- IDLE, branch!=0, ex_busy=0, lu=0:
  - pc_stall=1, if_id_cstall=1.
  - Next state BR_WAIT, counter loads 0.
- BR_WAIT, ex_busy=0:
  - if_id_cstall=1 and pc_stall=1 on every cycle without a resolve. The branch's ID/EX copy advances normally, so id_ex_stall=0.
  - On br_resolved=1:
    - if_id_cstall=0 and pc_stall=0 that cycle.
    - if_id_flush=br_taken.
    - Next state IDLE.
  - Otherwise the counter increments. When counter==BR_TIMEOUT:
    - Set br_timeout_err (sticky until reset) and release as for not-taken.
    - Next state IDLE.
- br_resolved while in IDLE is ignored.
- branch!=0 on the resolve cycle is a new branch: it is evaluated in the next cycle, in IDLE.
- The counter saturates and never wraps.
- A reset asserted mid BR_WAIT returns the block to IDLE immediately and asynchronously.

Optional Feature:
- Macro STALL_PERF_CNT_EN. When defined, the following are added, each PERF_W bits wide:
  - Ports perf_cstall_cycles, perf_dstall_cycles, perf_flush_count.
  - perf_cstall_cycles increments on cycles with if_id_cstall.
  - perf_dstall_cycles increments on cycles with if_id_dstall.
  - perf_flush_count increments on cycles with if_id_flush.
  - All three reset to 0 and wrap modulo 2^PERF_W.
- When undefined, neither the ports nor the logic exist. Behaviour is otherwise identical.

Decomposition:
- Shared package/header (common.vh):
  - State encoding: IDLE=1'b0, BR_WAIT=1'b1.
  - Branch type constant BR_NONE=2'b00.
  - Default REG_AW.
- One natural sub-module: load_use_detect, a purely combinational comparator producing lu.

Test Plan:
1. Reset with branch=2'b01 held -> all outputs 0. After release: one cycle with cstall=1 in IDLE, then BR_WAIT.
2. Branch accepted; br_resolved=1, br_taken=1 three cycles later -> cstall=1 for 3 cycles, then cstall=0 with if_id_flush=1 for 1 cycle, then IDLE.
3. id_ex_memread=1, id_ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_stall, if_id_dstall, id_ex_bubble =1 for one cycle. Repeat with rd=0 -> no stall.
4. Load-use plus branch=2'b10 in the same cycle -> one dstall/bubble cycle first; the branch is accepted in the following cycle.
5. In BR_WAIT, ex_busy=1 for 4 cycles with br_resolved pulsed during them -> resolve ignored, id_ex_stall=1, counter frozen. The branch releases only on a later resolve.
6. BR_TIMEOUT=3, no resolve -> release after 4 BR_WAIT cycles; br_timeout_err=1 and stays set until rst_n=0. With STALL_PERF_CNT_EN defined, perf_cstall_cycles=5.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  localparam logic [1:0]  BR_NONE    = 2'b00;
  localparam int unsigned REG_AW_DEF = 5;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads the register a load in EX writes.
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rd,
  output logic              lu
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = id_use_rs1 && (id_rs1 == id_ex_rd);
  assign w_hit_rs2 = id_use_rs2 && (id_rs2 == id_ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = id_ex_memread && (id_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: branch hold with watchdog, load-use and multi-cycle EX stalls.
// Optional perf counters enabled by macro STALL_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned BR_TIMEOUT = 15,
  parameter int unsigned CNT_W      = $clog2(BR_TIMEOUT + 1)
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        branch,
  input  logic              br_resolved,
  input  logic              br_taken,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              ex_busy,
  output logic              pc_stall,
  output logic              if_id_cstall,
  output logic              if_id_dstall,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_stall,
`ifdef STALL_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_cstall_cycles,
  output logic [PERF_W-1:0] perf_dstall_cycles,
  output logic [PERF_W-1:0] perf_flush_count,
`endif
  output logic              br_timeout_err
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             w_err_set;
  logic             w_lu;
  logic             w_pc;
  logic             w_cstall;
  logic             w_dstall;
  logic             w_flush;
  logic             w_bubble;
  logic             w_idex_stall;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lu (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_ex_memread(id_ex_memread),
    .id_ex_rd     (id_ex_rd),
    .lu           (w_lu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_err_set    = 1'b0;
    w_pc         = 1'b0;
    w_cstall     = 1'b0;
    w_dstall     = 1'b0;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    w_idex_stall = 1'b0;
    if (ex_busy) begin
      // Whole front end freezes; a pending branch keeps its control hold.
      w_pc         = 1'b1;
      w_dstall     = 1'b1;
      w_idex_stall = 1'b1;
      w_cstall     = (r_state == BR_WAIT);
    end else begin
      if (w_lu) begin
        w_pc     = 1'b1;
        w_dstall = 1'b1;
        w_bubble = 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if ((branch != BR_NONE) && !w_lu) begin
            w_pc        = 1'b1;
            w_cstall    = 1'b1;
            w_state_nxt = BR_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        BR_WAIT: begin
          if (br_resolved) begin
            w_flush     = br_taken;
            w_state_nxt = IDLE;
          end else begin
            w_pc     = 1'b1;
            w_cstall = 1'b1;
            // Watchdog: the last hold cycle still stalls, then releases as not-taken.
            if (r_cnt == CNT_W'(BR_TIMEOUT)) begin
              w_err_set   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign pc_stall       = rst_n & w_pc;
  assign if_id_cstall   = rst_n & w_cstall;
  assign if_id_dstall   = rst_n & w_dstall;
  assign if_id_flush    = rst_n & w_flush;
  assign id_ex_bubble   = rst_n & w_bubble;
  assign id_ex_stall    = rst_n & w_idex_stall;
  assign br_timeout_err = r_err;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_cstall;
  logic [PERF_W-1:0] r_perf_dstall;
  logic [PERF_W-1:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cstall <= '0;
      r_perf_dstall <= '0;
      r_perf_flush  <= '0;
    end else begin
      r_perf_cstall <= r_perf_cstall + PERF_W'(w_cstall);
      r_perf_dstall <= r_perf_dstall + PERF_W'(w_dstall);
      r_perf_flush  <= r_perf_flush + PERF_W'(w_flush);
    end
  end

  assign perf_cstall_cycles = r_perf_cstall;
  assign perf_dstall_cycles = r_perf_dstall;
  assign perf_flush_count   = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int unsigned TO = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] branch;
  logic       br_resolved, br_taken;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_use_rs1, id_use_rs2, id_ex_memread, ex_busy;
  logic       pc_stall, if_id_cstall, if_id_dstall, if_id_flush;
  logic       id_ex_bubble, id_ex_stall, br_timeout_err;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_cstall_cycles, perf_dstall_cycles, perf_flush_count;
  logic [31:0] m_perf_c = '0, m_perf_d = '0, m_perf_f = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(
    .REG_AW    (5),
    .BR_TIMEOUT(TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch            (branch),
    .br_resolved       (br_resolved),
    .br_taken          (br_taken),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .id_ex_memread     (id_ex_memread),
    .id_ex_rd          (id_ex_rd),
    .ex_busy           (ex_busy),
    .pc_stall          (pc_stall),
    .if_id_cstall      (if_id_cstall),
    .if_id_dstall      (if_id_dstall),
    .if_id_flush       (if_id_flush),
    .id_ex_bubble      (id_ex_bubble),
    .id_ex_stall       (id_ex_stall),
`ifdef STALL_PERF_CNT_EN
    .perf_cstall_cycles(perf_cstall_cycles),
    .perf_dstall_cycles(perf_dstall_cycles),
    .perf_flush_count  (perf_flush_count),
`endif
    .br_timeout_err    (br_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "waiting" flag, cycles already spent waiting, sticky error.
  bit m_wait = 1'b0;
  int m_waited = 0;
  bit m_err = 1'b0;

  typedef struct packed {
    logic pc, c, d, fl, bub, st;
  } exp_t;

  function automatic logic model_lu();
    return id_ex_memread && (id_ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic lu;
    e  = '0;
    lu = model_lu();
    if (ex_busy) begin
      e.pc = 1; e.d = 1; e.st = 1; e.c = m_wait;
    end else begin
      if (lu) begin
        e.pc = 1; e.d = 1; e.bub = 1;
      end
      if (!m_wait) begin
        if (branch != 0 && !lu) begin e.pc = 1; e.c = 1; end
      end else if (br_resolved) begin
        e.fl = br_taken;
      end else begin
        e.pc = 1; e.c = 1;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    exp_t e;
    if (!rst_n) begin
      m_wait <= 0; m_waited <= 0; m_err <= 0;
`ifdef STALL_PERF_CNT_EN
      m_perf_c <= '0; m_perf_d <= '0; m_perf_f <= '0;
`endif
    end else begin
      e = model_out();
`ifdef STALL_PERF_CNT_EN
      m_perf_c <= m_perf_c + 32'(e.c);
      m_perf_d <= m_perf_d + 32'(e.d);
      m_perf_f <= m_perf_f + 32'(e.fl);
`endif
      if (!ex_busy) begin
        if (!m_wait) begin
          if (branch != 0 && !model_lu()) begin m_wait <= 1; m_waited <= 0; end
        end else if (br_resolved) begin
          m_wait <= 0;
        end else if (m_waited == TO) begin
          m_wait <= 0; m_err <= 1;
        end else begin
          m_waited <= m_waited + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    exp_t e;
    e = rst_n ? model_out() : '0;
    chk("pc_stall", 32'(pc_stall), 32'(e.pc));
    chk("if_id_cstall", 32'(if_id_cstall), 32'(e.c));
    chk("if_id_dstall", 32'(if_id_dstall), 32'(e.d));
    chk("if_id_flush", 32'(if_id_flush), 32'(e.fl));
    chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
    chk("id_ex_stall", 32'(id_ex_stall), 32'(e.st));
    chk("br_timeout_err", 32'(br_timeout_err), 32'(m_err));
`ifdef STALL_PERF_CNT_EN
    chk("perf_cstall", perf_cstall_cycles, m_perf_c);
    chk("perf_dstall", perf_dstall_cycles, m_perf_d);
    chk("perf_flush", perf_flush_count, m_perf_f);
`endif
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch = 2'b00; br_resolved = 0; br_taken = 0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_ex_memread = 0; id_ex_rd = '0; ex_busy = 0;
  endtask

  initial begin
    clear_inputs();
    // 1: reset with a branch present
    branch = 2'b01;
    rst_n  = 1'b0;
    #3;
    chk("t1_rst_pc", 32'(pc_stall), 0);
    chk("t1_rst_cstall", 32'(if_id_cstall), 0);
    chk("t1_rst_err", 32'(br_timeout_err), 0);
    @(posedge clk);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk); chk("t1_accept_cstall", 32'(if_id_cstall), 1);
    next_cyc(); branch = 2'b00;
    // 2: resolve taken after three hold cycles
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_cstall", 32'(if_id_cstall), 1);
      chk("t2_hold_pc", 32'(pc_stall), 1);
      next_cyc();
    end
    br_resolved = 1; br_taken = 1;
    @(negedge clk);
    chk("t2_res_cstall", 32'(if_id_cstall), 0);
    chk("t2_res_flush", 32'(if_id_flush), 1);
    next_cyc(); br_resolved = 0; br_taken = 0;
    @(negedge clk); chk("t2_idle_pc", 32'(pc_stall), 0);
    // 3: load-use on rs2, then rd=0
    next_cyc();
    id_ex_memread = 1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
    @(negedge clk);
    chk("t3_lu_pc", 32'(pc_stall), 1);
    chk("t3_lu_dstall", 32'(if_id_dstall), 1);
    chk("t3_lu_bubble", 32'(id_ex_bubble), 1);
    next_cyc(); id_ex_rd = 5'd0;
    @(negedge clk);
    chk("t3_rd0_pc", 32'(pc_stall), 0);
    chk("t3_rd0_bubble", 32'(id_ex_bubble), 0);
    // 4: load-use together with a branch
    next_cyc(); id_ex_rd = 5'd5; branch = 2'b10;
    @(negedge clk);
    chk("t4_lu_bubble", 32'(id_ex_bubble), 1);
    chk("t4_lu_cstall", 32'(if_id_cstall), 0);
    next_cyc(); id_ex_memread = 0;
    @(negedge clk); chk("t4_accept_cstall", 32'(if_id_cstall), 1);
    next_cyc(); branch = 2'b00; br_resolved = 1; br_taken = 0;
    @(negedge clk);
    chk("t4_res_cstall", 32'(if_id_cstall), 0);
    chk("t4_res_flush", 32'(if_id_flush), 0);
    next_cyc(); br_resolved = 0;
    // 5: ex_busy during BR_WAIT freezes everything
    branch = 2'b11;
    @(negedge clk); chk("t5_accept_cstall", 32'(if_id_cstall), 1);
    next_cyc(); branch = 2'b00; ex_busy = 1;
    for (int i = 0; i < 4; i++) begin
      br_resolved = (i == 1); br_taken = (i == 1);
      @(negedge clk);
      chk("t5_busy_idex_stall", 32'(id_ex_stall), 1);
      chk("t5_busy_flush", 32'(if_id_flush), 0);
      next_cyc();
    end
    ex_busy = 0; br_resolved = 0; br_taken = 0;
    repeat (3) begin
      @(negedge clk); chk("t5_hold_cstall", 32'(if_id_cstall), 1);
      next_cyc();
    end
    br_resolved = 1; br_taken = 1;
    @(negedge clk); chk("t5_res_flush", 32'(if_id_flush), 1);
    next_cyc(); br_resolved = 0; br_taken = 0;
    @(negedge clk); chk("t5_no_timeout", 32'(br_timeout_err), 0);
    // 6: watchdog release
    next_cyc(); rst_n = 0;
    @(negedge clk); chk("t6_rst_err", 32'(br_timeout_err), 0);
    next_cyc(); rst_n = 1; branch = 2'b01;
    @(negedge clk); chk("t6_accept_cstall", 32'(if_id_cstall), 1);
    next_cyc(); branch = 2'b00;
    repeat (4) begin
      @(negedge clk); chk("t6_hold_cstall", 32'(if_id_cstall), 1);
      next_cyc();
    end
    @(negedge clk);
    chk("t6_rel_cstall", 32'(if_id_cstall), 0);
    chk("t6_rel_pc", 32'(pc_stall), 0);
    chk("t6_err_set", 32'(br_timeout_err), 1);
`ifdef STALL_PERF_CNT_EN
    chk("t6_perf_cstall", perf_cstall_cycles, 32'd5);
`endif
    repeat (4) next_cyc();
    @(negedge clk); chk("t6_err_sticky", 32'(br_timeout_err), 1);
    next_cyc(); rst_n = 0;
    #1; chk("t6_err_cleared", 32'(br_timeout_err), 0);
    next_cyc(); rst_n = 1;
    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      branch        = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      br_resolved   = ($urandom_range(0, 3) == 0);
      br_taken      = $urandom_range(0, 1) == 1;
      ex_busy       = ($urandom_range(0, 6) == 0);
      id_ex_memread = ($urandom_range(0, 9) < 3);
      id_ex_rd      = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1) == 1;
      id_use_rs2    = $urandom_range(0, 1) == 1;
      next_cyc();
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
